uart_mmio_fifo: RTL and testbench

Memory-mapped UART buffer between the CPU data bus and the existing `uart_tx` / `uart_rx` byte cores. It replaces the direct single-byte mapping with parametrised TX and RX FIFOs, occupancy counters, sticky overflow flags and flush control. Register offsets 0x0, 0x2 and 0x3 keep their current software-visible meaning. Sits in the 0xA address region of the top level.

---
 rtl/uart_mmio_fifo.sv | 212 +++++++++++++++++++++
 tb/tb_uart_mmio_fifo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART buffer: TX/RX FIFOs, occupancy counts, sticky overflow flags, flush control.
// Optional TX->RX loopback path is built only when UART_MMIO_LOOPBACK_EN is defined.
module uart_mmio_fifo #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_byte,
  input  logic        rx_ready,
  output logic        rx_ack
);
  localparam int TPW = $clog2(TX_DEPTH);
  localparam int TCW = TPW + 1;
  localparam int RPW = $clog2(RX_DEPTH);
  localparam int RCW = RPW + 1;

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GUARD} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_GUARD} rx_state_t;

  tx_state_t tx_state, tx_state_nxt;
  rx_state_t rx_state, rx_state_nxt;

  logic wr_tx, wr_pop, wr_ctrl;
  logic tx_flush, rx_flush, flag_clr;
  assign wr_tx    = sel && wr_valid && (addr == 4'h0);
  assign wr_pop   = sel && wr_valid && (addr == 4'h3);
  assign wr_ctrl  = sel && wr_valid && (addr == 4'h8);
  assign tx_flush = wr_ctrl && wr_data[0];
  assign rx_flush = wr_ctrl && wr_data[1];
  assign flag_clr = wr_ctrl && wr_data[2];

  logic unused_ok;
  assign unused_ok = ^wr_data[31:3];

  // ---------------- TX FIFO ----------------
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TPW-1:0] tx_wp, tx_rp;
  logic [TCW-1:0] tx_cnt;
  logic           tx_full, tx_empty, tx_do_push, tx_do_pop;
  logic [7:0]     tx_head;

  assign tx_full    = (tx_cnt == TCW'(TX_DEPTH));
  assign tx_empty   = (tx_cnt == '0);
  assign tx_head    = tx_mem[tx_rp];
  assign tx_do_push = wr_tx && !tx_full && !tx_flush;
  assign tx_do_pop  = (tx_state == TX_SEND) && !tx_empty && !tx_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
    end else if (tx_flush) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
    end else begin
      if (tx_do_push) tx_wp <= tx_wp + TPW'(1);
      if (tx_do_pop)  tx_rp <= tx_rp + TPW'(1);
      case ({tx_do_push, tx_do_pop})
        2'b10:   tx_cnt <= tx_cnt + TCW'(1);
        2'b01:   tx_cnt <= tx_cnt - TCW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (tx_do_push) tx_mem[tx_wp] <= wr_data[7:0];

  // ---------------- RX FIFO ----------------
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RPW-1:0] rx_wp, rx_rp;
  logic [RCW-1:0] rx_cnt;
  logic           rx_full, rx_empty, rx_push, rx_do_push, rx_do_pop;
  logic [7:0]     rx_head, rx_push_data;

  // Loopback hooks; tied off when the feature is not built.
  logic tx_go, lb_push, rx_en, lb_rd;

  assign rx_full    = (rx_cnt == RCW'(RX_DEPTH));
  assign rx_empty   = (rx_cnt == '0);
  assign rx_head    = rx_mem[rx_rp];
  assign rx_push    = (rx_state == RX_ACK) || lb_push;
  assign rx_push_data = lb_push ? tx_byte : rx_byte;
  assign rx_do_push = rx_push && !rx_full && !rx_flush;
  assign rx_do_pop  = wr_pop && !rx_empty && !rx_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else if (rx_flush) begin
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else begin
      if (rx_do_push) rx_wp <= rx_wp + RPW'(1);
      if (rx_do_pop)  rx_rp <= rx_rp + RPW'(1);
      case ({rx_do_push, rx_do_pop})
        2'b10:   rx_cnt <= rx_cnt + RCW'(1);
        2'b01:   rx_cnt <= rx_cnt - RCW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (rx_do_push) rx_mem[rx_wp] <= rx_push_data;

  // ---------------- Loopback ----------------
`ifdef UART_MMIO_LOOPBACK_EN
  logic loopback, lb_xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          loopback <= 1'b0;
    else if (wr_ctrl) loopback <= wr_data[3];
  end

  // Route chosen at hand-over so a mid-byte mode change cannot split a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                lb_xfer <= 1'b0;
    else if (tx_state == TX_IDLE && tx_go)  lb_xfer <= loopback;
  end

  assign tx_go    = !tx_empty && (loopback ? !rx_full : tx_ready);
  assign tx_valid = (tx_state == TX_SEND) && !lb_xfer;
  assign lb_push  = (tx_state == TX_SEND) && lb_xfer;
  assign rx_en    = !loopback;
  assign lb_rd    = loopback;
`else
  assign tx_go    = !tx_empty && tx_ready;
  assign tx_valid = (tx_state == TX_SEND);
  assign lb_push  = 1'b0;
  assign rx_en    = 1'b1;
  assign lb_rd    = 1'b0;
`endif

  // ---------------- TX drain FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_go) tx_state_nxt = TX_SEND;
      TX_SEND:  tx_state_nxt = TX_GUARD;
      TX_GUARD: tx_state_nxt = TX_IDLE;
      default:  tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               tx_byte <= 8'h00;
    else if (tx_state == TX_IDLE && tx_go) tx_byte <= tx_head;
  end

  // ---------------- RX fill FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_ready && !rx_full && rx_en) rx_state_nxt = RX_ACK;
      RX_ACK:   rx_state_nxt = RX_GUARD;
      RX_GUARD: rx_state_nxt = RX_IDLE;
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  assign rx_ack = (rx_state == RX_ACK);

  // ---------------- Sticky flags ----------------
  logic tx_ovf, rx_ovf, tx_ovf_set, rx_ovf_set;
  // A byte discarded by a same-cycle flush is not an overflow.
  assign tx_ovf_set = wr_tx && tx_full && !tx_flush;
  assign rx_ovf_set = rx_ready && rx_full && !rx_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_ovf <= 1'b0; rx_ovf <= 1'b0;
    end else begin
      if (tx_ovf_set)    tx_ovf <= 1'b1;
      else if (flag_clr) tx_ovf <= 1'b0;
      if (rx_ovf_set)    rx_ovf <= 1'b1;
      else if (flag_clr) rx_ovf <= 1'b0;
    end
  end

  // ---------------- Read mux ----------------
  always_comb begin
    rd_data = '0;
    if (sel) begin
      case (addr)
        4'h0: rd_data[0] = !tx_full;
        4'h2: rd_data[0] = !rx_empty;
        4'h3: if (!rx_empty) rd_data[7:0] = rx_head;
        4'h4: rd_data[15:0] = {8'(rx_cnt), 8'(tx_cnt)};
        4'h8: rd_data[3:0] = {lb_rd, 1'b0, tx_ovf, rx_ovf};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Scoreboard bench for uart_mmio_fifo: stimulus queues expectations, a negedge monitor checks them.
module tb_uart_mmio_fifo;
  localparam int TXD = 4;
  localparam int RXD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [3:0]  addr = '0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  rx_byte = '0;
  logic        rx_ready = 1'b0;
  logic        rx_ack;
  logic        rd_en = 1'b0;

  uart_mmio_fifo #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst(rst), .sel(sel), .addr(addr), .wr_valid(wr_valid),
    .wr_data(wr_data), .rd_data(rd_data), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_byte(rx_byte), .rx_ready(rx_ready), .rx_ack(rx_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] b; int c; } tx_exp_t;
  typedef struct { string n; logic [31:0] v; } rd_exp_t;

  tx_exp_t exp_tx[$];
  int      exp_ack[$];
  rd_exp_t exp_rd[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  tx_exp_t te;
  rd_exp_t re;
  int      ae;
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid) begin
        if (exp_tx.size() == 0) chk("tx_unexpected", {24'b0, tx_byte}, 32'hFFFF_FFFF);
        else begin
          te = exp_tx.pop_front();
          chk("tx_byte", {24'b0, tx_byte}, {24'b0, te.b});
          if (te.c >= 0) chk("tx_cycle", cyc, te.c);
        end
      end
      if (rx_ack) begin
        if (exp_ack.size() == 0) chk("rx_ack_unexpected", cyc, 32'hFFFF_FFFF);
        else begin
          ae = exp_ack.pop_front();
          if (ae >= 0) chk("rx_ack_cycle", cyc, ae);
        end
      end
      if (rd_en) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", rd_data, 32'hFFFF_FFFF);
        else begin
          re = exp_rd.pop_front();
          chk(re.n, rd_data, re.v);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    sel = 1'b0; wr_valid = 1'b0; rd_en = 1'b0; addr = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; addr = a; wr_valid = 1'b1; wr_data = d;
    step();
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] v, input string n);
    rd_exp_t e;
    e.n = n; e.v = v;
    exp_rd.push_back(e);
    sel = 1'b1; addr = a; rd_en = 1'b1;
    step();
  endtask

  // Read RX head and pop it in the same cycle.
  task automatic rdpop(input logic [7:0] v, input string n);
    rd_exp_t e;
    e.n = n; e.v = {24'b0, v};
    exp_rd.push_back(e);
    sel = 1'b1; addr = 4'h3; rd_en = 1'b1; wr_valid = 1'b1; wr_data = '0;
    step();
  endtask

  // uart_rx model: present a byte, expect ack next cycle, release, let the guard pass.
  task automatic rx_put(input logic [7:0] b);
    rx_byte = b; rx_ready = 1'b1;
    exp_ack.push_back(cyc + 1);
    step();
    rx_ready = 1'b0;
    step(); step();
  endtask

  task automatic push_tx(input logic [7:0] b, input int c);
    tx_exp_t e;
    e.b = b; e.c = c;
    exp_tx.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  int n, m;
  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_tx_valid", {31'b0, tx_valid}, 0);
    chk("rst_rx_ack",   {31'b0, rx_ack}, 0);
    chk("rst_tx_byte",  {24'b0, tx_byte}, 0);
    step();
    rd(4'h0, 32'h1, "rst_rd0");
    rd(4'h2, 32'h0, "rst_rd2");
    rd(4'h4, 32'h0, "rst_rd4");
    rd(4'h8, 32'h0, "rst_rd8");
    rd(4'h6, 32'h0, "unmapped_rd6");

    // Three back-to-back stores drain at N+2, N+5, N+8
    n = cyc;
    push_tx(8'h41, n + 2);
    push_tx(8'h42, n + 5);
    push_tx(8'h43, n + 8);
    wr(4'h0, 32'h41);
    wr(4'h0, 32'h42);
    wr(4'h0, 32'h43);
    repeat (8) step();
    rd(4'h4, 32'h0, "tx_drained_cnt");

    // Overfill TX with the core stalled
    tx_ready = 1'b0;
    wr(4'h0, 32'h10);
    rd(4'h4, 32'h0001, "tx_cnt_1");
    wr(4'h0, 32'h11);
    wr(4'h0, 32'h12);
    rd(4'h0, 32'h1, "tx_not_full_3");
    wr(4'h0, 32'h13);
    rd(4'h0, 32'h0, "tx_full_rd0");
    wr(4'h0, 32'h14);
    rd(4'h8, 32'h2, "tx_ovf_set");
    rd(4'h4, 32'h0004, "tx_cnt_full");
    for (int i = 0; i < TXD; i++) push_tx(8'(8'h10 + i), -1);
    tx_ready = 1'b1;
    repeat (3 * TXD + 4) step();
    rd(4'h4, 32'h0, "tx_cnt_after_drain");
    wr(4'h8, 32'h4);
    rd(4'h8, 32'h0, "flags_cleared_1");

    // RX: push and CPU pop in the same cycle keep the count
    rx_put(8'hA1);
    rx_put(8'hA2);
    rx_put(8'hA3);
    rd(4'h4, 32'h0300, "rx_cnt_3");
    m = cyc;
    rx_byte = 8'h55; rx_ready = 1'b1;
    exp_ack.push_back(m + 1);
    step();
    rx_ready = 1'b0;
    wr(4'h3, 32'h0);
    rd(4'h4, 32'h0300, "rx_cnt_push_pop");
    rdpop(8'hA2, "rx_head_a2");
    rdpop(8'hA3, "rx_head_a3");
    rdpop(8'h55, "rx_head_55");
    rd(4'h2, 32'h0, "rx_empty_rd2");
    rd(4'h3, 32'h0, "rx_empty_rd3");

    // RX full: no ack, overflow sticks through a same-cycle clear, flush recovers
    rx_put(8'hB0);
    rx_put(8'hB1);
    rx_put(8'hB2);
    rx_put(8'hB3);
    rd(4'h4, 32'h0400, "rx_cnt_full");
    rd(4'h2, 32'h1, "rx_not_empty");
    rx_byte = 8'hC0; rx_ready = 1'b1;
    repeat (3) step();
    rd(4'h8, 32'h1, "rx_ovf_set");
    wr(4'h8, 32'h4);
    rd(4'h8, 32'h1, "rx_ovf_clr_loses");
    exp_ack.push_back(-1);
    wr(4'h8, 32'h6);
    rd(4'h4, 32'h0, "rx_cnt_flushed");
    rd(4'h8, 32'h0, "flags_cleared_2");
    rx_ready = 1'b0;
    repeat (2) step();
    rd(4'h4, 32'h0100, "rx_cnt_after_flush_ack");
    rdpop(8'hC0, "rx_head_c0");

`ifdef UART_MMIO_LOOPBACK_EN
    // Loopback: TX byte lands in RX, tx_valid stays low even with tx_ready high
    tx_ready = 1'b1;
    wr(4'h8, 32'h8);
    wr(4'h0, 32'h5A);
    repeat (5) step();
    rd(4'h2, 32'h1, "lb_rx_not_empty");
    rd(4'h8, 32'h8, "lb_bit");
    rdpop(8'h5A, "lb_head");
    wr(4'h8, 32'h0);
`endif

    // Mid-operation reset clears everything
    tx_ready = 1'b0;
    wr(4'h0, 32'h77);
    wr(4'h0, 32'h78);
    rd(4'h4, 32'h0002, "pre_rst_cnt");
    rst = 1'b1;
    step();
    chk("mid_rst_tx_byte", {24'b0, tx_byte}, 0);
    chk("mid_rst_tx_valid", {31'b0, tx_valid}, 0);
    rst = 1'b0;
    tx_ready = 1'b1;
    rd(4'h4, 32'h0, "post_rst_cnt");
    rd(4'h0, 32'h1, "post_rst_rd0");
    repeat (6) step();

    chk("tx_queue_left",  exp_tx.size(), 0);
    chk("ack_queue_left", exp_ack.size(), 0);
    chk("rd_queue_left",  exp_rd.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
